// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the multicycle MIPS datapath.
//   src_e    - write-data source codes; the value is the MuxWriteData select
//   NUM_SRC  - number of write-data sources
//   SEL_W    - width of the write-data mux select
//   ADDR_W   - register address width
//   REG_ZERO - address of the hardwired $zero register
package mips_pkg;

    localparam int unsigned NUM_SRC = 8;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned ADDR_W  = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [SEL_W-1:0] {
        SRC_ALU   = 3'd0,
        SRC_EPC   = 3'd1,
        SRC_MDR   = 3'd2,
        SRC_SLT   = 3'd3,
        SRC_SHIFT = 3'd4,
        SRC_PC    = 3'd5,
        SRC_HILO  = 3'd6,
        SRC_R227  = 3'd7
    } src_e;

endpackage

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: combinational 8-way round-robin grant.
//   req_i   [7:0] request vector (already masked by the caller)
//   last_i  [2:0] index granted most recently; scan starts just after it
//   grant_o [7:0] one-hot grant, zero when nothing requests
//   idx_o   [2:0] index of the granted bit (equals last_i when no grant)
//   valid_o       a grant was issued
module rr_arbiter8 (
    input  logic [7:0] req_i,
    input  logic [2:0] last_i,
    output logic [7:0] grant_o,
    output logic [2:0] idx_o,
    output logic       valid_o
);

    always_comb begin
        logic [2:0] j;
        grant_o = '0;
        idx_o   = last_i;
        valid_o = 1'b0;
        j       = '0;
        // k runs 1..8 so that last_i itself is examined last; 3-bit add wraps mod 8.
        for (int unsigned k = 1; k <= 8; k++) begin
            j = last_i + k[2:0];
            if (!valid_o && req_i[j]) begin
                valid_o    = 1'b1;
                idx_o      = j;
                grant_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: schedules register-file write-back among the eight
// write-data sources. EPC preempts; the rest share round-robin.
//   clk          rising-edge clock
//   reset        asynchronous, active-high
//   req          per-source write request
//   dst          packed destination registers, dst[i*ADDR_W +: ADDR_W] for source i
//   stall        register file unavailable, no grant
//   flush        exception flush, only EPC may be granted
//   grant        combinational one-hot grant
//   MuxWriteData registered write-data mux select
//   RegWrite     registered write-enable pulse (suppressed for $zero)
//   WriteReg     registered destination register
//   busy         registered: a request was left ungranted last cycle
module writeback_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned P_NUM_SRC = NUM_SRC,
    parameter int unsigned P_SEL_W   = SEL_W,
    parameter int unsigned P_ADDR_W  = ADDR_W
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [P_NUM_SRC-1:0]            req,
    input  logic [P_NUM_SRC*P_ADDR_W-1:0]   dst,
    input  logic                            stall,
    input  logic                            flush,
    output logic [P_NUM_SRC-1:0]            grant,
    output logic [P_SEL_W-1:0]              MuxWriteData,
    output logic                            RegWrite,
    output logic [P_ADDR_W-1:0]             WriteReg,
    output logic                            busy
);

    localparam logic [P_NUM_SRC-1:0] EPC_BIT = P_NUM_SRC'(1) << SRC_EPC;

    logic [P_SEL_W-1:0]   mux_q, mux_d;
    logic                 rw_q, rw_d;
    logic [P_ADDR_W-1:0]  wreg_q, wreg_d;
    logic                 busy_q, busy_d;
    logic [P_SEL_W-1:0]   last_q, last_d;

    logic [P_ADDR_W-1:0]  dst_arr [P_NUM_SRC];
    logic [P_NUM_SRC-1:0] rr_grant;
    logic [P_SEL_W-1:0]   rr_idx;
    logic                 rr_valid;
    logic                 epc_req;
    logic [P_SEL_W-1:0]   gidx;

    always_comb begin
        for (int unsigned i = 0; i < P_NUM_SRC; i++) begin
            dst_arr[i] = dst[i*P_ADDR_W +: P_ADDR_W];
        end
    end

    assign epc_req = req[SRC_EPC];

    // EPC is removed from the round-robin pool; it is handled by the override below.
    rr_arbiter8 u_rr (
        .req_i   (req & ~EPC_BIT),
        .last_i  (last_q),
        .grant_o (rr_grant),
        .idx_o   (rr_idx),
        .valid_o (rr_valid)
    );

    always_comb begin
        grant = '0;
        gidx  = rr_idx;
        if (stall) begin
            grant = '0;
        end else if (epc_req) begin
            grant = EPC_BIT;
            gidx  = SRC_EPC;
        end else if (!flush && rr_valid) begin
            grant = rr_grant;
        end
    end

    always_comb begin
        mux_d  = mux_q;
        wreg_d = wreg_q;
        last_d = last_q;
        rw_d   = 1'b0;
        busy_d = |(req & ~grant);
        if (|grant) begin
            mux_d  = gidx;
            wreg_d = dst_arr[gidx];
            last_d = gidx;
            rw_d   = (dst_arr[gidx] != REG_ZERO);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mux_q  <= '0;
            rw_q   <= 1'b0;
            wreg_q <= '0;
            busy_q <= 1'b0;
            last_q <= SRC_R227;
        end else begin
            mux_q  <= mux_d;
            rw_q   <= rw_d;
            wreg_q <= wreg_d;
            busy_q <= busy_d;
            last_q <= last_d;
        end
    end

    assign MuxWriteData = mux_q;
    assign RegWrite     = rw_q;
    assign WriteReg     = wreg_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

    logic        clk;
    logic        reset;
    logic [7:0]  req;
    logic [39:0] dst;
    logic        stall;
    logic        flush;
    logic [7:0]  grant;
    logic [2:0]  MuxWriteData;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    writeback_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .dst          (dst),
        .stall        (stall),
        .flush        (flush),
        .grant        (grant),
        .MuxWriteData (MuxWriteData),
        .RegWrite     (RegWrite),
        .WriteReg     (WriteReg),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dst(input int idx, input logic [4:0] val);
        dst[idx*5 +: 5] = val;
    endtask

    initial begin
        int seq [8];
        seq = '{0, 2, 3, 4, 5, 6, 7, 0};

        reset = 1'b1; req = '0; dst = '0; stall = 1'b0; flush = 1'b0;
        step();
        check("rst_mux",   32'(MuxWriteData), 0);
        check("rst_rw",    32'(RegWrite), 0);
        check("rst_wreg",  32'(WriteReg), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_grant", 32'(grant), 0);

        // 1: single ALU write
        reset = 1'b0; set_dst(0, 5'd9); req = 8'h01; #1;
        check("t1_grant", 32'(grant), 32'h01);
        step();
        req = 8'h00; #1;
        check("t1_rw",    32'(RegWrite), 1);
        check("t1_mux",   32'(MuxWriteData), 0);
        check("t1_wreg",  32'(WriteReg), 9);
        check("t1_grant0", 32'(grant), 0);
        step();
        check("t1_rw_off", 32'(RegWrite), 0);

        // 2: all round-robin sources held, pointer freshly reset
        reset = 1'b1; #1; reset = 1'b0;
        for (int i = 0; i < 8; i++) set_dst(i, 5'(i + 1));
        req = 8'hFD; #1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t2_grant%0d", k), 32'(grant), 32'(1) << seq[k]);
            if (k > 0) begin
                check($sformatf("t2_rw%0d", k),   32'(RegWrite), 1);
                check($sformatf("t2_mux%0d", k),  32'(MuxWriteData), 32'(seq[k-1]));
                check($sformatf("t2_wreg%0d", k), 32'(WriteReg), 32'(seq[k-1] + 1));
            end
            step();
        end
        req = 8'h00; #1;
        check("t2_mux_last",  32'(MuxWriteData), 0);
        check("t2_wreg_last", 32'(WriteReg), 1);
        check("t2_rw_last",   32'(RegWrite), 1);
        check("t2_busy",      32'(busy), 1);
        step();

        // 3: EPC preempts, then scan resumes after source 1
        req = 8'h42; #1;
        check("t3_grant_epc", 32'(grant), 32'h02);
        step();
        req = 8'h40; #1;
        check("t3_grant_hilo", 32'(grant), 32'h40);
        check("t3_mux_epc",    32'(MuxWriteData), 1);
        check("t3_wreg_epc",   32'(WriteReg), 2);
        check("t3_rw_epc",     32'(RegWrite), 1);
        step();
        req = 8'h00; #1;
        check("t3_mux_hilo",  32'(MuxWriteData), 6);
        check("t3_wreg_hilo", 32'(WriteReg), 7);
        step();

        // 4: stall for three cycles
        req = 8'h11; stall = 1'b1; #1;
        check("t4_grant_s1", 32'(grant), 0);
        step();
        check("t4_grant_s2", 32'(grant), 0);
        check("t4_rw_s2",    32'(RegWrite), 0);
        check("t4_busy_s2",  32'(busy), 1);
        step();
        check("t4_grant_s3", 32'(grant), 0);
        check("t4_rw_s3",    32'(RegWrite), 0);
        check("t4_busy_s3",  32'(busy), 1);
        step();
        stall = 1'b0; #1;
        check("t4_grant_rel", 32'(grant), 32'h01);
        check("t4_rw_rel",    32'(RegWrite), 0);
        step();
        req = 8'h10; #1;
        check("t4_grant_shift", 32'(grant), 32'h10);
        check("t4_mux_alu",     32'(MuxWriteData), 0);
        check("t4_wreg_alu",    32'(WriteReg), 1);
        check("t4_rw_alu",      32'(RegWrite), 1);
        step();
        req = 8'h00; #1;
        check("t4_mux_shift",  32'(MuxWriteData), 4);
        check("t4_wreg_shift", 32'(WriteReg), 5);
        step();

        // 5: flush lets only EPC through
        flush = 1'b1; req = 8'h24; #1;
        check("t5_grant_flush", 32'(grant), 0);
        step();
        req = 8'h26; #1;
        check("t5_grant_epc", 32'(grant), 32'h02);
        check("t5_busy",      32'(busy), 1);
        step();
        flush = 1'b0; req = 8'h24; #1;
        check("t5_grant_mdr", 32'(grant), 32'h04);
        check("t5_mux_epc",   32'(MuxWriteData), 1);
        check("t5_wreg_epc",  32'(WriteReg), 2);
        check("t5_rw_epc",    32'(RegWrite), 1);
        step();
        req = 8'h20; #1;
        check("t5_grant_pc", 32'(grant), 32'h20);
        check("t5_mux_mdr",  32'(MuxWriteData), 2);
        check("t5_wreg_mdr", 32'(WriteReg), 3);
        step();
        req = 8'h00; #1;
        check("t5_mux_pc",  32'(MuxWriteData), 5);
        check("t5_wreg_pc", 32'(WriteReg), 6);
        step();

        // 6: $zero destination, then reset while RegWrite is high
        set_dst(3, 5'd0); req = 8'h08; #1;
        check("t6_grant_slt", 32'(grant), 32'h08);
        step();
        req = 8'h10; #1;
        check("t6_grant_shift", 32'(grant), 32'h10);
        check("t6_rw_zero",     32'(RegWrite), 0);
        check("t6_mux_slt",     32'(MuxWriteData), 3);
        check("t6_wreg_zero",   32'(WriteReg), 0);
        step();
        req = 8'h00; #1;
        check("t6_rw_pre",   32'(RegWrite), 1);
        check("t6_mux_pre",  32'(MuxWriteData), 4);
        check("t6_wreg_pre", 32'(WriteReg), 5);
        reset = 1'b1; #1;
        check("t6_rst_rw",   32'(RegWrite), 0);
        check("t6_rst_mux",  32'(MuxWriteData), 0);
        check("t6_rst_wreg", 32'(WriteReg), 0);
        check("t6_rst_busy", 32'(busy), 0);
        reset = 1'b0; req = 8'hFD; #1;
        check("t6_grant_restart", 32'(grant), 32'h01);
        step();
        req = 8'h00; #1;
        check("t6_rw_restart",  32'(RegWrite), 1);
        check("t6_mux_restart", 32'(MuxWriteData), 0);
        check("t6_wreg_restart", 32'(WriteReg), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
